// File: rtl/mul_stage_ctrl_if.sv
// Op/result handshake bundle between EXE, mul_stage_ctrl and MEM/WB.
// master = surrounding pipeline, slave = mul_stage_ctrl.
interface mul_stage_ctrl_if #(
    parameter int unsigned TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_src1;
    logic [31:0]      in_src2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/mul_stage_ctrl.sv
// Two-stage controller around the combinational multiplier: S1 drives the multiplier,
// S2 holds the selected 32-bit result. Optional perf counters under MUL_PERF_CNT_EN.
module mul_stage_ctrl #(
    parameter int unsigned TAG_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    mul_stage_ctrl_if.slave     bus,
    input  logic                flush,
    output logic [31:0]         mul_x,
    output logic [31:0]         mul_y,
    output logic                mul_signed,
    input  logic [63:0]         mul_product,
    output logic                busy
`ifdef MUL_PERF_CNT_EN
    ,
    output logic [31:0]         perf_mul_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);

    logic             s1_valid_q;
    logic             s1_hi_q;
    logic             s1_signed_q;
    logic [31:0]      s1_src1_q;
    logic [31:0]      s1_src2_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic             s2_valid_q;
    logic [31:0]      s2_result_q;
    logic [TAG_W-1:0] s2_tag_q;

    logic        s2_ready;
    logic        s1_adv;
    logic        in_ready;
    logic        accept;
    logic [31:0] s1_result;

    always_comb begin
        s2_ready  = ~s2_valid_q | bus.out_ready;
        s1_adv    = s1_valid_q & s2_ready & ~flush;
        in_ready  = (~s1_valid_q | s2_ready) & ~flush;
        accept    = bus.in_valid & in_ready;
        s1_result = s1_hi_q ? mul_product[63:32] : mul_product[31:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_hi_q     <= 1'b0;
            s1_signed_q <= 1'b0;
            s1_src1_q   <= '0;
            s1_src2_q   <= '0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_tag_q    <= '0;
        end else begin
            if (flush) begin
                s1_valid_q <= 1'b0;
                s2_valid_q <= 1'b0;
            end else begin
                s1_valid_q <= accept | (s1_valid_q & ~s1_adv);
                s2_valid_q <= s1_adv | (s2_valid_q & ~bus.out_ready);
            end
            // Operands only change on accept so the multiplier inputs stay quiet when idle.
            if (accept) begin
                s1_hi_q     <= (bus.in_op == 2'b01) | (bus.in_op == 2'b10);
                s1_signed_q <= (bus.in_op == 2'b01);
                s1_src1_q   <= bus.in_src1;
                s1_src2_q   <= bus.in_src2;
                s1_tag_q    <= bus.in_tag;
            end
            if (s1_adv) begin
                s2_result_q <= s1_result;
                s2_tag_q    <= s1_tag_q;
            end
        end
    end

    assign mul_x          = s1_src1_q;
    assign mul_y          = s1_src2_q;
    assign mul_signed     = s1_signed_q;
    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = s2_valid_q;
    assign bus.out_result = s2_result_q;
    assign bus.out_tag    = s2_tag_q;
    assign busy           = s1_valid_q | s2_valid_q;

`ifdef MUL_PERF_CNT_EN
    logic [31:0] perf_mul_cnt_q;
    logic [31:0] perf_stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_mul_cnt_q   <= '0;
            perf_stall_cnt_q <= '0;
        end else begin
            if (s2_valid_q & bus.out_ready & ~flush) begin
                perf_mul_cnt_q <= perf_mul_cnt_q + 32'd1;
            end
            if (bus.in_valid & ~in_ready & ~flush) begin
                perf_stall_cnt_q <= perf_stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_mul_cnt   = perf_mul_cnt_q;
    assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_mul_stage_ctrl.sv
// Self-checking bench for mul_stage_ctrl: 2-deep FIFO model with min latency of one edge,
// plus literal expectations for the completed-op sequence.
module tb_mul_stage_ctrl;
    localparam int unsigned TAG_W = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] mul_x;
    logic [31:0] mul_y;
    logic        mul_signed;
    logic [63:0] mul_product;
    logic        busy;
`ifdef MUL_PERF_CNT_EN
    logic [31:0] perf_mul_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    mul_stage_ctrl_if #(.TAG_W(TAG_W)) bus ();

    mul_stage_ctrl #(.TAG_W(TAG_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .flush       (flush),
        .mul_x       (mul_x),
        .mul_y       (mul_y),
        .mul_signed  (mul_signed),
        .mul_product (mul_product),
        .busy        (busy)
`ifdef MUL_PERF_CNT_EN
        ,
        .perf_mul_cnt   (perf_mul_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in for the combinational multiplier.
    always_comb begin
        mul_product = mul_signed ? ({{32{mul_x[31]}}, mul_x} * {{32{mul_y[31]}}, mul_y})
                                 : ({32'd0, mul_x} * {32'd0, mul_y});
    end

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        bit               fresh;
    } ent_t;

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
    } done_t;

    ent_t  mq[$];
    done_t log_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    live = 1'b0;
    logic [31:0] m_x = '0;
    logic [31:0] m_y = '0;
    logic        m_signed = 1'b0;
    logic [31:0] m_mul_cnt = '0;
    logic [31:0] m_stall_cnt = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'd0, a} * {32'd0, b};
        case (op)
            2'b01:   return sp[63:32];
            2'b10:   return up[63:32];
            default: return up[31:0];
        endcase
    endfunction

    // Model: ops form a FIFO of at most two; the head is visible once it has aged one edge.
    always @(negedge clk) begin
        bit    ov;
        bit    ir;
        ent_t  e;
        done_t d;
        ov = (mq.size() > 0) && !mq[0].fresh;
        ir = !flush && ((mq.size() < 2) || bus.out_ready);
        if (live) begin
            check("out_valid", bus.out_valid, ov);
            check("in_ready", bus.in_ready, ir);
            check("busy", busy, mq.size() > 0);
            check("mul_x", mul_x, m_x);
            check("mul_y", mul_y, m_y);
            check("mul_signed", mul_signed, m_signed);
            if (ov) begin
                check("out_result", bus.out_result, mq[0].res);
                check("out_tag", bus.out_tag, mq[0].tag);
            end
`ifdef MUL_PERF_CNT_EN
            check("perf_mul_cnt", perf_mul_cnt, m_mul_cnt);
            check("perf_stall_cnt", perf_stall_cnt, m_stall_cnt);
`endif
            if (bus.out_valid && bus.out_ready && !flush && !reset) begin
                d.res = bus.out_result;
                d.tag = bus.out_tag;
                log_q.push_back(d);
            end
        end
        if (reset) begin
            mq.delete();
            m_x = '0;
            m_y = '0;
            m_signed = 1'b0;
            m_mul_cnt = '0;
            m_stall_cnt = '0;
            live = 1'b1;
        end else if (live) begin
            if (flush) begin
                mq.delete();
            end else begin
                if (ov && bus.out_ready) begin
                    mq.delete(0);
                    m_mul_cnt++;
                end
                foreach (mq[i]) mq[i].fresh = 1'b0;
                if (bus.in_valid && ir) begin
                    e.res   = ref_result(bus.in_op, bus.in_src1, bus.in_src2);
                    e.tag   = bus.in_tag;
                    e.fresh = 1'b1;
                    mq.push_back(e);
                    m_x = bus.in_src1;
                    m_y = bus.in_src2;
                    m_signed = (bus.in_op == 2'b01);
                end
                if (bus.in_valid && !ir) m_stall_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] t);
        bit done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_src1  = a;
        bus.in_src2  = b;
        bus.in_tag   = t;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            done = bus.in_ready;
            tick();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: tag %0d never accepted", t);
        end
        bus.in_valid = 1'b0;
    endtask

    logic [TAG_W-1:0] exp_tag[14] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd1, 5'd2, 5'd3,
                                      5'd10, 5'd11, 5'd12, 5'd16, 5'd19};
    logic [31:0] exp_res[14] = '{32'h00000001, 32'h00000000, 32'hFFFFFFFE, 32'h40000000,
                                 32'h00000001, 32'h0000002A, 32'h0000000F, 32'h00000001,
                                 32'hFFFFFFFA, 32'h00012340, 32'h00000000, 32'h00000001,
                                 32'h00000051, 32'h0000000F};
    logic [1:0]  lat_op[3] = '{2'b00, 2'b01, 2'b10};

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_src1   = '0;
        bus.in_src2   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_mul_x", mul_x, 0);
        check("rst_out_result", bus.out_result, 0);

        // All-ones operands with the latency pinned per op.
        for (int i = 0; i < 3; i++) begin
            issue(lat_op[i], 32'hFFFFFFFF, 32'hFFFFFFFF, 5'(i + 1));
            check("lat_e0", bus.out_valid, 0);
            tick();
            check("lat_e1", bus.out_valid, 1);
            tick();
        end

        issue(2'b01, 32'h80000000, 32'h80000000, 5'd4);
        issue(2'b10, 32'h80000000, 32'h00000002, 5'd5);
        issue(2'b11, 32'd7, 32'd6, 5'd6);
        repeat (3) tick();

        issue(2'b00, 32'd5, 32'd3, 5'd1);
        issue(2'b10, 32'h00010000, 32'h00010000, 5'd2);
        issue(2'b00, 32'hFFFFFFFE, 32'd3, 5'd3);
        repeat (3) tick();

        // Backpressure: fill both stages, third op must wait.
        bus.out_ready = 1'b0;
        issue(2'b00, 32'h00001234, 32'h00000010, 5'd10);
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11);
        fork
            issue(2'b10, 32'hFFFFFFFF, 32'h00000002, 5'd12);
            begin
                check("bp_in_ready", bus.in_ready, 0);
                repeat (3) begin
                    tick();
                    check("bp_hold_result", bus.out_result, 32'h00012340);
                    check("bp_hold_tag", bus.out_tag, 10);
                end
                bus.out_ready = 1'b1;
            end
        join
        repeat (4) tick();

        // Flush with both stages full and a new op offered.
        bus.out_ready = 1'b0;
        issue(2'b00, 32'd2, 32'd2, 5'd13);
        issue(2'b00, 32'd4, 32'd4, 5'd14);
        bus.in_valid  = 1'b1;
        bus.in_op     = 2'b00;
        bus.in_src1   = 32'd8;
        bus.in_src2   = 32'd8;
        bus.in_tag    = 5'd15;
        bus.out_ready = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", bus.in_ready, 0);
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_out_valid", bus.out_valid, 0);
        check("flush_busy", busy, 0);
        issue(2'b00, 32'd9, 32'd9, 5'd16);
        repeat (3) tick();

        // Reset with two ops in flight.
        bus.out_ready = 1'b0;
        issue(2'b00, 32'd5, 32'd5, 5'd17);
        issue(2'b01, 32'd6, 32'd6, 5'd18);
        reset = 1'b1;
        tick();
        check("rst2_out_valid", bus.out_valid, 0);
        check("rst2_busy", busy, 0);
        check("rst2_mul_x", mul_x, 0);
        check("rst2_mul_y", mul_y, 0);
`ifdef MUL_PERF_CNT_EN
        check("rst2_perf_mul", perf_mul_cnt, 0);
        check("rst2_perf_stall", perf_stall_cnt, 0);
`endif
        reset = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        issue(2'b00, 32'd3, 32'd5, 5'd19);
        repeat (3) tick();

        check("log_count", log_q.size(), 14);
        for (int i = 0; i < 14 && i < log_q.size(); i++) begin
            check("log_tag", log_q[i].tag, exp_tag[i]);
            check("log_result", log_q[i].res, exp_res[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
